// File: rtl/keypad_pkg.sv
// Shared definitions for the decimal keypad entry block: key codes, state
// encodings and small combinational helpers.
package keypad_pkg;

    // key_code = 4*row + col on the 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D matrix
    localparam logic [3:0] KEY_1     = 4'h0;
    localparam logic [3:0] KEY_2     = 4'h1;
    localparam logic [3:0] KEY_3     = 4'h2;
    localparam logic [3:0] KEY_4     = 4'h4;
    localparam logic [3:0] KEY_5     = 4'h5;
    localparam logic [3:0] KEY_6     = 4'h6;
    localparam logic [3:0] KEY_7     = 4'h8;
    localparam logic [3:0] KEY_8     = 4'h9;
    localparam logic [3:0] KEY_9     = 4'hA;
    localparam logic [3:0] KEY_0     = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_BS    = 4'h7;
    localparam logic [3:0] KEY_CLR   = 4'hC;

    typedef enum logic [1:0] {
        SC_SCAN     = 2'd0,
        SC_PRESS_DB = 2'd1,
        SC_HELD     = 2'd2,
        SC_REL_DB   = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        CV_IDLE = 2'd0,
        CV_CONV = 2'd1,
        CV_DONE = 2'd2
    } conv_state_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] value;
    } digit_t;

    function automatic digit_t code_to_digit(input logic [3:0] code);
        digit_t d;
        d.is_digit = 1'b1;
        d.value    = 4'd0;
        case (code)
            KEY_0:   d.value = 4'd0;
            KEY_1:   d.value = 4'd1;
            KEY_2:   d.value = 4'd2;
            KEY_3:   d.value = 4'd3;
            KEY_4:   d.value = 4'd4;
            KEY_5:   d.value = 4'd5;
            KEY_6:   d.value = 4'd6;
            KEY_7:   d.value = 4'd7;
            KEY_8:   d.value = 4'd8;
            KEY_9:   d.value = 4'd9;
            default: begin
                d.is_digit = 1'b0;
                d.value    = 4'd0;
            end
        endcase
        return d;
    endfunction

    // Rows are active-low; the lowest asserted row index has priority.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0]) begin
            r = 2'd0;
        end else if (!rows[1]) begin
            r = 2'd1;
        end else if (!rows[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    // acc*10 + d using shifts; 9999 is the largest result so 14 bits suffice.
    function automatic logic [13:0] mul10_add(input logic [13:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {10'd0, d};
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner with press/release debounce for a 4x4 active-low keypad.
// Emits a single key_stb pulse with key_code per debounced physical press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_stb,
    output logic [3:0] key_code
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

    scan_state_t      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [3:0]       col_out_q, col_out_d;
    logic             key_stb_q, key_stb_d;
    logic [3:0]       key_code_q, key_code_d;

    // State register for the scanner and its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SC_SCAN;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
            div_q      <= '0;
            db_q       <= '0;
            col_out_q  <= 4'b1110;
            key_stb_q  <= 1'b0;
            key_code_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            div_q      <= div_d;
            db_q       <= db_d;
            col_out_q  <= col_out_d;
            key_stb_q  <= key_stb_d;
            key_code_q <= key_code_d;
        end
    end

    // Next-state logic: rotate columns, qualify press and release
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        div_d      = div_q;
        db_d       = db_q;
        key_stb_d  = 1'b0;
        key_code_d = key_code_q;

        case (state_q)
            SC_SCAN: begin
                if (div_q == DIV_LAST) begin
                    if (row_in != 4'hF) begin
                        // Column stays frozen while the press is qualified
                        row_d   = lowest_low_row(row_in);
                        db_d    = '0;
                        state_d = SC_PRESS_DB;
                    end else begin
                        col_d = col_q + 2'd1;
                        div_d = '0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SC_PRESS_DB: begin
                if (!row_in[row_q]) begin
                    if (db_q == DB_LAST) begin
                        key_stb_d  = 1'b1;
                        key_code_d = {row_q, col_q};
                        state_d    = SC_HELD;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end else begin
                    div_d   = '0;
                    state_d = SC_SCAN;
                end
            end
            SC_HELD: begin
                if (row_in == 4'hF) begin
                    db_d    = '0;
                    state_d = SC_REL_DB;
                end else begin
                    state_d = SC_HELD;
                end
            end
            SC_REL_DB: begin
                if (row_in == 4'hF) begin
                    if (db_q == DB_LAST) begin
                        col_d   = col_q + 2'd1;
                        div_d   = '0;
                        state_d = SC_SCAN;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end else begin
                    state_d = SC_HELD;
                end
            end
            default: begin
                col_d   = 2'd0;
                div_d   = '0;
                state_d = SC_SCAN;
            end
        endcase

        col_out_d = ~(4'b0001 << col_d);
    end

    assign col_out  = col_out_q;
    assign key_stb  = key_stb_q;
    assign key_code = key_code_q;

endmodule

// File: rtl/keypad_dec2bin.sv
// Decimal keypad entry: buffers up to four BCD digits from the scanner and
// converts them MSD-first to a 14-bit binary value when ENTER is pressed.
module keypad_dec2bin
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] bcd16,
    output logic [2:0]  digit_cnt,
    output logic [13:0] out14,
    output logic        out_valid,
    output logic        busy,
    output logic        key_err
);

    logic       key_stb_s;
    logic [3:0] key_code_s;

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_stb  (key_stb_s),
        .key_code (key_code_s)
    );

    conv_state_t state_q, state_d;
    logic [1:0]  iter_q, iter_d;
    logic [13:0] acc_q, acc_d;
    logic [15:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [13:0] out14_q, out14_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        key_err_q, key_err_d;

    digit_t      dig_s;
    logic [3:0]  nibble_s;
    logic [13:0] acc_nxt_s;

    // Entry buffer, conversion FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CV_IDLE;
            iter_q      <= 2'd0;
            acc_q       <= 14'd0;
            bcd_q       <= 16'h0000;
            cnt_q       <= 3'd0;
            out14_q     <= 14'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            out14_q     <= out14_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            key_err_q   <= key_err_d;
        end
    end

    // Key handling in IDLE and the four-step multiply-by-ten accumulation
    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        acc_d       = acc_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        out14_d     = out14_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        key_err_d   = 1'b0;

        dig_s     = code_to_digit(key_code_s);
        nibble_s  = bcd_q[{iter_q, 2'b00} +: 4];
        acc_nxt_s = mul10_add(acc_q, nibble_s);

        case (state_q)
            CV_IDLE: begin
                if (key_stb_s) begin
                    if (dig_s.is_digit) begin
                        if (cnt_q == 3'd4) begin
                            key_err_d = 1'b1;
                        end else begin
                            bcd_d = {bcd_q[11:0], dig_s.value};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code_s == KEY_BS) begin
                        if (cnt_q != 3'd0) begin
                            bcd_d = {4'h0, bcd_q[15:4]};
                            cnt_d = cnt_q - 3'd1;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else if (key_code_s == KEY_CLR) begin
                        bcd_d = 16'h0000;
                        cnt_d = 3'd0;
                    end else if (key_code_s == KEY_ENTER) begin
                        acc_d   = 14'd0;
                        iter_d  = 2'd3;
                        busy_d  = 1'b1;
                        state_d = CV_CONV;
                    end else begin
                        state_d = CV_IDLE;
                    end
                end else begin
                    state_d = CV_IDLE;
                end
            end
            CV_CONV: begin
                acc_d = acc_nxt_s;
                if (iter_q == 2'd0) begin
                    // Last digit folded in: publish straight from the adder
                    out14_d     = acc_nxt_s;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    bcd_d       = 16'h0000;
                    cnt_d       = 3'd0;
                    state_d     = CV_DONE;
                end else begin
                    iter_d = iter_q - 2'd1;
                end
            end
            CV_DONE: begin
                state_d = CV_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = CV_IDLE;
            end
        endcase
    end

    assign bcd16     = bcd_q;
    assign digit_cnt = cnt_q;
    assign out14     = out14_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign key_err   = key_err_q;

endmodule
